wb_arbiter2: RTL and testbench

- Two-master Wishbone (classic, single-beat) arbiter that shares the CPU-side bus between the a23_core (master 0) and a second bus master (master 1, e.g. a Tube/RAM DMA engine).
- Its single slave port drives the existing wb_switch master interface.
- Provides round-robin arbitration, cycle-level bus locking and an optional bus watchdog.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_arbiter2_if.sv | 27 ++
 rtl/wb_arb_watchdog.sv | 30 +++
 rtl/wb_arbiter2.sv | 131 +++++++++++++
 tb/tb_wb_arbiter2.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and arbiter state encoding
// used by the two-master arbiter slice.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter2_if.sv
// Classic single-beat Wishbone bus bundle.
// master: drives adr/sel/we/cyc/stb/dat_w, gets dat_r/ack/err.
interface wb_arbiter2_if
  import wb_pkg::*;
();

  logic [WB_ADR_W-1:0] adr;
  logic [WB_SEL_W-1:0] sel;
  logic                we;
  logic                cyc;
  logic                stb;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;
  logic                err;

  modport master (
    output adr, sel, we, cyc, stb, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, sel, we, cyc, stb, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles, pulses fire
// for one cycle at TIMEOUT_CYCLES. Ports: clk, reset, stall, fire.
module wb_arb_watchdog #(
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic fire
);

  localparam logic [TIMEOUT_W-1:0] LIMIT =
    TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] cnt;

  assign fire = (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (fire || !stall) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cyc bus lock.
// Ports: clk, reset, m0/m1 (slave side of each master bus),
// s (master side toward wb_switch), grant_o (one-hot owner).
// Optional watchdog enabled by macro WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s,
  output logic [1:0]    grant_o
);

  import wb_pkg::*;

  if (TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES does not fit TIMEOUT_W");
  end

  arb_state_t state;
  arb_state_t state_nxt;
  // pref: master that wins when both request in IDLE
  logic       pref;
  logic       pref_nxt;
  logic       wd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      pref  <= 1'b0;
    end else begin
      state <= state_nxt;
      pref  <= pref_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pref_nxt  = pref;
    unique case (state)
      ARB_IDLE: begin
        if (m0.cyc && (!m1.cyc || !pref)) begin
          state_nxt = ARB_OWN0;
        end else if (m1.cyc) begin
          state_nxt = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!m0.cyc) begin
          pref_nxt  = 1'b1;
          state_nxt = m1.cyc ? ARB_OWN1 : ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        if (!m1.cyc) begin
          pref_nxt  = 1'b0;
          state_nxt = m0.cyc ? ARB_OWN0 : ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    s.adr   = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.dat_w = '0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    grant_o = 2'b00;
    case (state)
      ARB_OWN0: begin
        s.adr   = m0.adr;
        s.sel   = m0.sel;
        s.we    = m0.we;
        s.cyc   = m0.cyc;
        s.stb   = m0.stb & ~wd_fire;
        s.dat_w = m0.dat_w;
        m0.ack  = s.ack & m0.cyc & m0.stb & ~wd_fire;
        m0.err  = (s.err & m0.cyc & m0.stb) | wd_fire;
        grant_o = 2'b01;
      end
      ARB_OWN1: begin
        s.adr   = m1.adr;
        s.sel   = m1.sel;
        s.we    = m1.we;
        s.cyc   = m1.cyc;
        s.stb   = m1.stb & ~wd_fire;
        s.dat_w = m1.dat_w;
        m1.ack  = s.ack & m1.cyc & m1.stb & ~wd_fire;
        m1.err  = (s.err & m1.cyc & m1.stb) | wd_fire;
        grant_o = 2'b10;
      end
      default: ;
    endcase
  end

  // read data is broadcast; masters qualify it with ack
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

`ifdef WB_ARB_TIMEOUT_EN
  logic stall;

  assign stall =
    ((state == ARB_OWN0) & m0.cyc & m0.stb |
     (state == ARB_OWN1) & m1.cyc & m1.stb) &
    ~s.ack & ~s.err;

  wb_arb_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wd (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .fire  (wd_fire)
  );
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed spec scenarios plus random
// traffic compared against an ownership-level reference model.
module tb_wb_arbiter2;

  import wb_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: owner -1 idle, 0/1 master; pref wins ties
  int owner = -1;
  int pref  = 0;
  int wd    = 0;
  logic stall_m;
  logic own_req;
  logic oth_req;

  wb_arbiter2_if m0_bus ();
  wb_arbiter2_if m1_bus ();
  wb_arbiter2_if s_bus ();

  wb_arbiter2 #(
    .TIMEOUT_W      (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      owner = -1;
      pref  = 0;
      wd    = 0;
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      stall_m = (owner == 0 && m0_bus.cyc && m0_bus.stb) ||
                (owner == 1 && m1_bus.cyc && m1_bus.stb);
      stall_m = stall_m && !s_bus.ack && !s_bus.err;
      if (wd == TO || !stall_m) wd = 0;
      else wd = wd + 1;
`endif
      if (owner < 0) begin
        if (m0_bus.cyc && m1_bus.cyc) owner = pref;
        else if (m0_bus.cyc) owner = 0;
        else if (m1_bus.cyc) owner = 1;
      end else begin
        own_req = (owner == 0) ? m0_bus.cyc : m1_bus.cyc;
        oth_req = (owner == 0) ? m1_bus.cyc : m0_bus.cyc;
        if (!own_req) begin
          pref  = 1 - owner;
          owner = oth_req ? 1 - owner : -1;
        end
      end
    end
  end

  logic [31:0] e_adr, e_dat;
  logic [3:0]  e_sel;
  logic        e_we, e_cyc, e_stb, e_fire;
  logic        e_a0, e_a1, e_e0, e_e1;
  logic [1:0]  e_g;

  always @(negedge clk) begin
    if (chk_en) begin
      e_fire = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      e_fire = (owner >= 0) && (wd == TO);
`endif
      e_adr = '0; e_dat = '0; e_sel = '0;
      e_we = 0; e_cyc = 0; e_stb = 0; e_g = 2'b00;
      e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0;
      if (owner == 0) begin
        e_adr = m0_bus.adr; e_dat = m0_bus.dat_w;
        e_sel = m0_bus.sel; e_we = m0_bus.we;
        e_cyc = m0_bus.cyc;
        e_stb = m0_bus.stb && !e_fire;
        e_a0 = s_bus.ack && m0_bus.cyc && m0_bus.stb && !e_fire;
        e_e0 = (s_bus.err && m0_bus.cyc && m0_bus.stb) || e_fire;
        e_g = 2'b01;
      end else if (owner == 1) begin
        e_adr = m1_bus.adr; e_dat = m1_bus.dat_w;
        e_sel = m1_bus.sel; e_we = m1_bus.we;
        e_cyc = m1_bus.cyc;
        e_stb = m1_bus.stb && !e_fire;
        e_a1 = s_bus.ack && m1_bus.cyc && m1_bus.stb && !e_fire;
        e_e1 = (s_bus.err && m1_bus.cyc && m1_bus.stb) || e_fire;
        e_g = 2'b10;
      end
      check("m_grant", 32'(grant), 32'(e_g));
      check("m_s_adr", s_bus.adr, e_adr);
      check("m_s_dat", s_bus.dat_w, e_dat);
      check("m_s_sel", 32'(s_bus.sel), 32'(e_sel));
      check("m_s_ctl",
            {29'd0, s_bus.we, s_bus.cyc, s_bus.stb},
            {29'd0, e_we, e_cyc, e_stb});
      check("m_acks",
            {28'd0, m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err},
            {28'd0, e_a0, e_a1, e_e0, e_e1});
      check("m_dat_r",
            m0_bus.dat_r ^ m1_bus.dat_r ^ s_bus.dat_r,
            s_bus.dat_r);
    end
  end

  task automatic rand_inputs();
    if (m0_bus.cyc) begin
      if ($urandom_range(0, 99) < 25) begin
        m0_bus.cyc = 0; m0_bus.stb = 0;
      end else m0_bus.stb = ($urandom_range(0, 99) < 75);
    end else if ($urandom_range(0, 99) < 40) begin
      m0_bus.cyc = 1; m0_bus.stb = ($urandom_range(0, 99) < 75);
    end
    if (m1_bus.cyc) begin
      if ($urandom_range(0, 99) < 25) begin
        m1_bus.cyc = 0; m1_bus.stb = 0;
      end else m1_bus.stb = ($urandom_range(0, 99) < 75);
    end else if ($urandom_range(0, 99) < 40) begin
      m1_bus.cyc = 1; m1_bus.stb = ($urandom_range(0, 99) < 75);
    end
    m0_bus.adr = $urandom; m0_bus.dat_w = $urandom;
    m0_bus.sel = 4'($urandom); m0_bus.we = 1'($urandom);
    m1_bus.adr = $urandom; m1_bus.dat_w = $urandom;
    m1_bus.sel = 4'($urandom); m1_bus.we = 1'($urandom);
    s_bus.ack   = ($urandom_range(0, 99) < 35);
    s_bus.err   = ($urandom_range(0, 99) < 10);
    s_bus.dat_r = $urandom;
    reset = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    reset = 1;
    m0_bus.adr = 0; m0_bus.sel = 0; m0_bus.we = 0;
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.dat_w = 0;
    m1_bus.adr = 0; m1_bus.sel = 0; m1_bus.we = 0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.dat_w = 0;
    s_bus.dat_r = 0; s_bus.ack = 0; s_bus.err = 0;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    at_neg();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_cyc", 32'(s_bus.cyc), 32'h0);
    check("rst_model", 32'(owner), 32'hFFFF_FFFF);

    // single m0 read
    tick();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    m0_bus.adr = 32'h10; m0_bus.sel = 4'hF;
    at_neg();
    check("t1_latency", 32'(s_bus.stb), 32'h0);
    tick();
    at_neg();
    check("t1_stb", 32'(s_bus.stb), 32'h1);
    check("t1_adr", s_bus.adr, 32'h10);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_model", 32'(owner), 32'h0);
    tick();
    tick();
    s_bus.ack = 1; s_bus.dat_r = 32'hDEADBEEF;
    at_neg();
    check("t1_ack0", 32'(m0_bus.ack), 32'h1);
    check("t1_dat", m0_bus.dat_r, 32'hDEADBEEF);
    check("t1_ack1", 32'(m1_bus.ack), 32'h0);
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0; s_bus.ack = 0;
    tick();
    at_neg();
    check("t1_idle", 32'(grant), 32'h0);

    // simultaneous from reset, then handover
    reset = 1;
    tick();
    reset = 0;
    m0_bus.cyc = 1; m0_bus.stb = 1;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'h44;
    tick();
    at_neg();
    check("t2_first", 32'(grant), 32'h1);
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0;
    at_neg();
    check("t2_hold", 32'(grant), 32'h1);
    tick();
    at_neg();
    check("t2_handover", 32'(grant), 32'h2);
    check("t2_adr", s_bus.adr, 32'h44);

    // round robin, both always re-requesting
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i % 2 == 0) begin
        m1_bus.cyc = 0; m0_bus.cyc = 1; m0_bus.stb = 1;
      end else begin
        m0_bus.cyc = 0; m1_bus.cyc = 1;
      end
      tick();
      if (i % 2 == 0) m1_bus.cyc = 1;
      else m0_bus.cyc = 1;
      at_neg();
      check("t3_rr", 32'(grant),
            (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // lock: three beats on m0 while m1 waits
    tick();
    m0_bus.stb = 1; m0_bus.we = 0; m0_bus.adr = 32'h80;
    m1_bus.stb = 1; m1_bus.adr = 32'h90;
    at_neg();
    check("t4_b1_adr", s_bus.adr, 32'h80);
    tick();
    m0_bus.stb = 0;
    at_neg();
    check("t4_b2_grant", 32'(grant), 32'h1);
    check("t4_b2_stb", 32'(s_bus.stb), 32'h0);
    tick();
    m0_bus.stb = 1; m0_bus.we = 1;
    m0_bus.dat_w = 32'h12345678; m0_bus.sel = 4'b0011;
    s_bus.ack = 1;
    at_neg();
    check("t4_b3_dat", s_bus.dat_w, 32'h12345678);
    check("t4_b3_sel", 32'(s_bus.sel), 32'h3);
    check("t4_b3_we", 32'(s_bus.we), 32'h1);
    check("t4_b3_ack0", 32'(m0_bus.ack), 32'h1);
    check("t4_b3_ack1", 32'(m1_bus.ack), 32'h0);
    tick();
    s_bus.ack = 0; m0_bus.cyc = 0; m0_bus.stb = 0;
    at_neg();
    check("t4_drop", 32'(grant), 32'h1);
    tick();
    at_neg();
    check("t4_m1", 32'(grant), 32'h2);
    check("t4_m1_adr", s_bus.adr, 32'h90);

    // reset while m1 owns with stb pending
    tick();
    reset = 1;
    tick();
    reset = 0;
    m1_bus.cyc = 0; m1_bus.stb = 0;
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h20;
    at_neg();
    check("t5_grant", 32'(grant), 32'h0);
    check("t5_s",
          {29'd0, s_bus.cyc, s_bus.stb, s_bus.we}, 32'h0);
    check("t5_adr", s_bus.adr, 32'h0);
    tick();
    at_neg();
    check("t5_regrant", 32'(grant), 32'h1);
    check("t5_adr2", s_bus.adr, 32'h20);
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0;
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    m0_bus.cyc = 1; m0_bus.stb = 1;
    s_bus.ack = 0; s_bus.err = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      at_neg();
      check("t6_err", 32'(m0_bus.err), (k == 17) ? 32'h1 : 32'h0);
      check("t6_grant", 32'(grant), 32'h1);
      if (k == 17) check("t6_stb", 32'(s_bus.stb), 32'h0);
    end
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0;
    tick();
`endif

    for (int n = 0; n < 3000; n++) begin
      tick();
      rand_inputs();
    end
    tick();
    reset = 0;
    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
